// File: rtl/file_uart_streamer.sv
// file_uart_streamer: FIFO-buffers reader byte strobes and drains them as 8N1 UART frames, LSB first.
// Optional CRLF_EXPAND_EN: each popped 0x0A goes out as a 0x0D frame followed by a 0x0A frame.
module file_uart_streamer #(
    parameter int unsigned CLK_DIV         = 868,
    parameter int unsigned FIFO_DEPTH_LOG2 = 6
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_en,
    input  logic [7:0]               in_byte,
    output logic                     uart_tx,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     fifo_full,
    output logic                     overflow,
    output logic                     busy
);
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]              BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]   DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic                       overflow_q, overflow_d;
    logic                       push, pop, full, empty;
    logic [7:0]                 head, load_byte;
    logic                       load_pend;

    state_e        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          pend_q, pend_d;
    logic          tx_q, tx_d;

    assign full       = (count_q == DEPTH_CNT);
    assign empty      = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    // A pop in the same cycle frees a slot, so a full FIFO can still take a byte.
    assign push       = in_en & (~full | pop);
    assign overflow_d = overflow_q | (in_en & ~push);

`ifdef CRLF_EXPAND_EN
    assign load_pend = (head == 8'h0A);
    assign load_byte = load_pend ? 8'h0D : head;
`else
    assign load_pend = 1'b0;
    assign load_byte = head;
`endif

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_byte;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            pend_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            pend_q     <= pend_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pend_d  = pend_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = load_byte;
                    pend_d  = load_pend;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    // A pending LF goes out ahead of the FIFO without consuming an entry.
                    if (pend_q) begin
                        shift_d = 8'h0A;
                        pend_d  = 1'b0;
                        state_d = START;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        shift_d = load_byte;
                        pend_d  = load_pend;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign uart_tx    = tx_q;
    assign fifo_count = count_q;
    assign fifo_full  = full;
    assign overflow   = overflow_q;
    assign busy       = (state_q != IDLE) | ~empty | pend_q;

endmodule

// File: tb/tb_file_uart_streamer.sv
// Self-checking bench for file_uart_streamer at CLK_DIV=4, depth 4: vector table plus frame scoreboard.
module tb_file_uart_streamer;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DLOG2   = 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             in_en = 1'b0;
    logic [7:0]       in_byte = '0;
    logic             uart_tx;
    logic [DLOG2:0]   fifo_count;
    logic             fifo_full;
    logic             overflow;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int start_q[$];

    file_uart_streamer #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH_LOG2(DLOG2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_en      (in_en),
        .in_byte    (in_byte),
        .uart_tx    (uart_tx),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame monitor: detects the start bit, samples mid-bit, compares against the scoreboard.
    logic       mon_act = 1'b0;
    int         mon_t = 0;
    logic [9:0] mon_bits = '0;
    always @(negedge clk) begin
        if (!resetn) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (uart_tx === 1'b0) begin
                mon_act = 1'b1;
                mon_t   = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_t++;
            if (mon_t % 4 == 2) mon_bits[mon_t / 4] = uart_tx;
            if (mon_t == 39) begin
                mon_act = 1'b0;
                check("frame_start_bit", 32'(mon_bits[0]), 32'd0);
                check("frame_stop_bit", 32'(mon_bits[9]), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_frame: got %0h, expected no frame", mon_bits[8:1]);
                end else begin
                    check("sb_frame_byte", 32'(mon_bits[8:1]), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b, input bit accept);
        in_byte = b;
        in_en   = 1'b1;
        @(posedge clk);
        #1;
        in_en = 1'b0;
        if (accept) begin
`ifdef CRLF_EXPAND_EN
            if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [7:0] b;
        logic [9:0] pat;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int n, s0;
        int bad;
        logic [7:0] fill_cnt[6];

        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'hA5, 10'b1101001010};
        vecs[4] = '{8'h01, 10'b1000000010};
        vecs[5] = '{8'h80, 10'b1100000000};
        vecs[6] = '{8'hC3, 10'b1110000110};

        tick(3);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        tick(2);

        // Single-byte frames, bit-exact at 4 cycles per bit.
        for (int i = 0; i < 7; i++) begin
            strobe(vecs[i].b, 1'b1);
            check("vec_count_after_push", 32'(fifo_count), 32'd1);
            check("vec_busy_after_push", 32'(busy), 32'd1);
            tick(1);
            check("vec_tx_falls", 32'(uart_tx), 32'd0);
            check("vec_count_after_pop", 32'(fifo_count), 32'd0);
            for (int k = 0; k < 10; k++) begin
                tick(2);
                check("vec_serial_bit", 32'(uart_tx), 32'(vecs[i].pat[k]));
                tick(1);
                #0;
                @(posedge clk);
            end
            #1;
            check("vec_busy_drop_40", 32'(busy), 32'd0);
            check("vec_tx_idle", 32'(uart_tx), 32'd1);
            tick(3);
        end

        // Burst of three: back-to-back frames, occupancy tracks pushes and pops.
        s0 = start_q.size();
        strobe(8'h41, 1'b1);
        check("burst_count_1", 32'(fifo_count), 32'd1);
        strobe(8'h42, 1'b1);
        check("burst_count_2", 32'(fifo_count), 32'd1);
        strobe(8'h43, 1'b1);
        check("burst_count_3", 32'(fifo_count), 32'd2);
        tick(38);
        check("burst_count_pre_pop", 32'(fifo_count), 32'd2);
        tick(1);
        check("burst_count_pop2", 32'(fifo_count), 32'd1);
        tick(40);
        check("burst_count_pop3", 32'(fifo_count), 32'd0);
        wait_idle(n);
        check("burst_tail_cycles", 32'(n), 32'd40);
        check("burst_frames", 32'(start_q.size() - s0), 32'd3);
        if (start_q.size() - s0 == 3) begin
            check("burst_gap_1", 32'(start_q[s0 + 1] - start_q[s0]), 32'd40);
            check("burst_gap_2", 32'(start_q[s0 + 2] - start_q[s0 + 1]), 32'd40);
        end
        tick(3);

        // Full FIFO with a push on the final STOP cycle: accepted via the simultaneous pop.
        s0 = start_q.size();
        fill_cnt = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4};
        for (int i = 0; i < 5; i++) begin
            strobe(8'h20 + 8'(i), 1'b1);
            check("full_fill_count", 32'(fifo_count), 32'(fill_cnt[i]));
        end
        tick(36);
        check("full_before_stop_full", 32'(fifo_full), 32'd1);
        check("full_before_stop_count", 32'(fifo_count), 32'd4);
        strobe(8'h25, 1'b1);
        check("full_simul_count", 32'(fifo_count), 32'd4);
        check("full_simul_overflow", 32'(overflow), 32'd0);
        check("full_simul_full", 32'(fifo_full), 32'd1);
        wait_idle(n);
        check("full_frames", 32'(start_q.size() - s0), 32'd6);
        tick(3);

        // Overflow: six strobes into an idle depth-4 FIFO, the sixth is dropped.
        s0 = start_q.size();
        for (int i = 0; i < 6; i++) begin
            strobe(8'h10 + 8'(i), i < 5);
            check("ovf_count", 32'(fifo_count), 32'(fill_cnt[i]));
            check("ovf_flag", 32'(overflow), (i == 5) ? 32'd1 : 32'd0);
        end
        check("ovf_full", 32'(fifo_full), 32'd1);
        wait_idle(n);
        check("ovf_frames", 32'(start_q.size() - s0), 32'd5);
        check("ovf_sticky", 32'(overflow), 32'd1);
        tick(3);

        // Asynchronous reset in the middle of DATA.
        strobe(8'h00, 1'b1);
        strobe(8'h00, 1'b1);
        strobe(8'h33, 1'b1);
        tick(10);
        check("midrst_tx_in_data", 32'(uart_tx), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_tx", 32'(uart_tx), 32'd1);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        tick(2);
        resetn = 1'b1;
        s0  = start_q.size();
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("postrst_quiet_cycles", 32'(bad), 32'd0);
        check("postrst_no_frame", 32'(start_q.size() - s0), 32'd0);
        strobe(8'h3C, 1'b1);
        wait_idle(n);
        check("postrst_new_frame", 32'(start_q.size() - s0), 32'd1);
        tick(3);

        // Line feed: CR+LF expansion when enabled, verbatim otherwise.
        s0 = start_q.size();
        strobe(8'h0A, 1'b1);
        wait_idle(n);
`ifdef CRLF_EXPAND_EN
        check("lf_busy_cycles", 32'(n), 32'd81);
        check("lf_frames", 32'(start_q.size() - s0), 32'd2);
        if (start_q.size() - s0 == 2)
            check("lf_gap", 32'(start_q[s0 + 1] - start_q[s0]), 32'd40);
`else
        check("lf_busy_cycles", 32'(n), 32'd41);
        check("lf_frames", 32'(start_q.size() - s0), 32'd1);
`endif
        tick(5);
        check("sb_all_frames_seen", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
